ic74138_scan_ctrl: RTL

//  Sequential scan controller sitting directly upstream of the ic74138 3-to-8 decoder.
//  - Steps through a masked set of 8 channels: drives select plus g1/g2a/g2b so exactly one

---
 rtl/ic74138_pkg.sv | 16 +
 rtl/ic74138_next_ch.sv | 32 +++
 rtl/ic74138_scan_ctrl.sv | 137 +++++++++++++
 3 files changed

// File: rtl/ic74138_pkg.sv
// Shared types and constants for the ic74138 scan controller.
package ic74138_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BLANK = 2'd1,
      DRIVE = 2'd2
   } scan_state_e;

   localparam int NUM_CH = 8;

   // {g1, g2a, g2b} patterns that enable/disable the decoder
   localparam logic [2:0] DEC_ON  = 3'b100;
   localparam logic [2:0] DEC_OFF = 3'b011;

endpackage

// File: rtl/ic74138_next_ch.sv
// Circular priority finder: first set mask bit strictly after cur, wrapping
// around so cur itself is the last candidate. wrap flags a non-increasing step.
module ic74138_next_ch
   import ic74138_pkg::*;
(
   input  logic [7:0] mask,
   input  logic [2:0] cur,
   output logic [2:0] nxt,
   output logic       found,
   output logic       wrap
);

   logic [2:0] idx_s;

   // Scan cur+1, cur+2, ... cur+8 (mod 8) and keep the first hit
   always_comb begin
      nxt   = 3'd0;
      found = 1'b0;
      idx_s = 3'd0;
      for (int i = 1; i <= NUM_CH; i++) begin
         idx_s = cur + 3'(i);
         if (!found && mask[idx_s]) begin
            nxt   = idx_s;
            found = 1'b1;
         end else begin
            found = found;
         end
      end
      wrap = found && (nxt <= cur);
   end

endmodule

// File: rtl/ic74138_scan_ctrl.sv
// Scan controller for an ic74138 decoder: visits masked channels in order,
// driving each for a dwell time with a decoder-disabled blanking gap between.
module ic74138_scan_ctrl
   import ic74138_pkg::*;
#(
   parameter int DWELL_W      = 16,
   parameter int BLANK_CYCLES = 4
)(
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               en_i,
   input  logic [DWELL_W-1:0] dwell_i,
   input  logic [7:0]         ch_mask_i,
   output logic               g1_o,
   output logic               g2a_o,
   output logic               g2b_o,
   output logic [2:0]         select_o,
   output logic               frame_o,
   output logic               busy_o
);

   localparam logic [7:0] BLANK_LOAD = 8'(BLANK_CYCLES - 1);

   scan_state_e        state_r;
   logic [2:0]         select_r;
   logic [2:0]         dec_en_r;
   logic               frame_r;
   logic               busy_r;
   logic [7:0]         blank_cnt_r;
   logic [DWELL_W-1:0] dwell_cnt_r;

   logic [2:0]         search_cur_s;
   logic [2:0]         nxt_s;
   logic               found_s;
   logic               wrap_s;
   logic [DWELL_W-1:0] dwell_load_s;

   // From IDLE the search starts after channel 7 so it lands on the lowest set bit
   always_comb begin
      if (state_r == IDLE) begin
         search_cur_s = 3'd7;
      end else begin
         search_cur_s = select_r;
      end
   end

   // Dwell counter load: counts down to zero, a dwell of 0 behaves like 1
   always_comb begin
      if (dwell_i == '0) begin
         dwell_load_s = '0;
      end else begin
         dwell_load_s = dwell_i - DWELL_W'(1);
      end
   end

   ic74138_next_ch u_next_ch (
      .mask  (ch_mask_i),
      .cur   (search_cur_s),
      .nxt   (nxt_s),
      .found (found_s),
      .wrap  (wrap_s)
   );

   // Scan FSM with registered decoder controls; select only moves while the decoder is off
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_r     <= IDLE;
         select_r    <= 3'd0;
         dec_en_r    <= DEC_OFF;
         frame_r     <= 1'b0;
         busy_r      <= 1'b0;
         blank_cnt_r <= 8'd0;
         dwell_cnt_r <= '0;
      end else begin
         frame_r <= 1'b0;
         case (state_r)
            IDLE: begin
               dec_en_r <= DEC_OFF;
               if (en_i && found_s) begin
                  state_r     <= BLANK;
                  select_r    <= nxt_s;
                  blank_cnt_r <= BLANK_LOAD;
                  busy_r      <= 1'b1;
               end else begin
                  busy_r <= 1'b0;
               end
            end
            BLANK: begin
               if (!en_i) begin
                  state_r  <= IDLE;
                  dec_en_r <= DEC_OFF;
                  busy_r   <= 1'b0;
               end else if (blank_cnt_r == 8'd0) begin
                  state_r     <= DRIVE;
                  dec_en_r    <= DEC_ON;
                  dwell_cnt_r <= dwell_load_s;
               end else begin
                  blank_cnt_r <= blank_cnt_r - 8'd1;
               end
            end
            DRIVE: begin
               if (!en_i) begin
                  state_r  <= IDLE;
                  dec_en_r <= DEC_OFF;
                  busy_r   <= 1'b0;
               end else if (dwell_cnt_r == '0) begin
                  dec_en_r <= DEC_OFF;
                  if (found_s) begin
                     state_r     <= BLANK;
                     select_r    <= nxt_s;
                     frame_r     <= wrap_s;
                     blank_cnt_r <= BLANK_LOAD;
                  end else begin
                     state_r <= IDLE;
                     busy_r  <= 1'b0;
                  end
               end else begin
                  dwell_cnt_r <= dwell_cnt_r - DWELL_W'(1);
               end
            end
            default: begin
               state_r  <= IDLE;
               dec_en_r <= DEC_OFF;
               busy_r   <= 1'b0;
            end
         endcase
      end
   end

   assign g1_o     = dec_en_r[2];
   assign g2a_o    = dec_en_r[1];
   assign g2b_o    = dec_en_r[0];
   assign select_o = select_r;
   assign frame_o  = frame_r;
   assign busy_o   = busy_r;

endmodule
